// File: rtl/maclaurin_pkg.sv
// maclaurin_pkg: shared state type and constants for the maclaurin_feeder sequencer
package maclaurin_pkg;

   localparam int XW       = 8;
   localparam int NW       = 3;
   localparam int DMIN_LO  = 3;
   localparam int DMIN_HI  = 7;
   localparam int N_THRESH = 4;

   typedef enum logic [2:0] {IDLE, START, SETN, FEED, DRAIN, CLR, GAP} state_t;

   // Minimum DRAIN residency for a given term count
   function automatic int dmin(input logic [NW-1:0] n);
      return (int'(n) <= N_THRESH) ? DMIN_LO : DMIN_HI;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample FIFO whose head register always holds the front entry
module sample_fifo
   import maclaurin_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [XW-1:0] din,
   input  logic          pop,
   output logic [XW-1:0] head,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [XW-1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr, rd_nx;
   logic [CW-1:0] cnt, cnt_pop, cnt_nx;
   logic          do_push, do_pop;

   // A push into a full FIFO is legal only when the same cycle pops
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      rd_nx   = rd + AW'(do_pop);
      cnt_pop = cnt - CW'(do_pop);
      cnt_nx  = cnt_pop + CW'(do_push);
   end

   // Storage array, written at the tail
   always_ff @(posedge clk) begin
      if (do_push) mem[wr] <= din;
   end

   // Pointers, occupancy flags and head; head holds its last value while empty
   always_ff @(posedge clk) begin
      if (rst) begin
         rd    <= '0;
         wr    <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         head  <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         rd    <= rd_nx;
         cnt   <= cnt_nx;
         full  <= (cnt_nx == CW'(DEPTH));
         empty <= (cnt_nx == '0);
         head  <= (cnt_pop == '0) ? (do_push ? din : head) : mem[rd_nx];
      end
   end

endmodule

// File: rtl/maclaurin_feeder.sv
// maclaurin_feeder: buffers samples and runs start/N/X-stream/drain/clear batches on the maclauren core
// Optional FEEDER_STATS_EN: enables saturating overflow/error counters on ovf_cnt/err_cnt.
module maclaurin_feeder
   import maclaurin_pkg::*;
#(
   parameter int DEPTH         = 32,
   parameter int CW            = $clog2(DEPTH + 1),
   parameter int DRAIN_TIMEOUT = 63
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [XW-1:0] in_data,
   output logic          in_ready,
   input  logic          go,
   input  logic [NW-1:0] n_cfg,
   input  logic [CW-1:0] count,
   output logic          busy,
   output logic          done,
   output logic          cfg_err,
   output logic          timeout,
   output logic          core_start,
   output logic [NW-1:0] core_N,
   output logic [XW-1:0] core_X,
   output logic          core_rst,
   input  logic          core_ready,
   input  logic          core_valid,
   input  logic          core_overflow,
   input  logic          core_error,
   output logic [15:0]   ovf_cnt,
   output logic [15:0]   err_cnt
);

   localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

   state_t        state;
   logic [CW-1:0] cnt_q, issued, received;
   logic [DW-1:0] dcnt;
   logic [XW-1:0] head;
   logic          full, empty, pop, go_ok, counting, rcv_ok, drain_end;

   sample_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid & in_ready),
      .din   (in_data),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign in_ready = ~full;
   assign core_X   = head;

   // Pop and batch-exit decisions derived from current state and counters
   always_comb begin
      pop       = (state == FEED) & core_ready & ~empty;
      go_ok     = (count != '0) & (count <= CW'(DEPTH));
      counting  = (state == START) | (state == SETN) | (state == FEED) | (state == DRAIN);
      rcv_ok    = (received == cnt_q) & (int'(dcnt) >= dmin(core_N) - 1);
      drain_end = int'(dcnt) == DRAIN_TIMEOUT - 1;
   end

   // Batch sequencer with registered strobes and status
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         timeout    <= 1'b0;
         core_start <= 1'b0;
         core_rst   <= 1'b0;
         core_N     <= '0;
         cnt_q      <= '0;
         issued     <= '0;
         received   <= '0;
         dcnt       <= '0;
      end else begin
         core_start <= 1'b0;
         core_rst   <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         if (counting && core_valid && received != '1) received <= received + 1'b1;
         case (state)
            IDLE: if (go) begin
               if (go_ok) begin
                  core_N     <= n_cfg;
                  cnt_q      <= count;
                  issued     <= '0;
                  received   <= '0;
                  timeout    <= 1'b0;
                  core_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= START;
               end else begin
                  cfg_err <= 1'b1;
               end
            end
            START: state <= SETN;
            SETN:  state <= FEED;
            FEED: if (pop) begin
               issued <= issued + 1'b1;
               if (issued + 1'b1 == cnt_q) begin
                  dcnt  <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               dcnt <= dcnt + 1'b1;
               if (rcv_ok || drain_end) begin
                  timeout  <= ~rcv_ok;
                  core_rst <= 1'b1;
                  state    <= CLR;
               end
            end
            CLR: state <= GAP;
            GAP: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FEEDER_STATS_EN
   // Saturating counters of core overflow results and error cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (core_valid && core_overflow && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
         if (core_error && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = core_overflow ^ core_error;
   assign ovf_cnt      = '0;
   assign err_cnt      = '0;
`endif

endmodule

// File: doc/maclaurin_feeder.md
# maclaurin_feeder

Initiator-side sequencer for the `maclauren` series core. It buffers signed 8-bit samples from an upstream writer and runs one batch per command: it pulses `start`, presents the term count N, and streams X samples under the core's `ready` handshake. It then drains results by counting `valid` and clears the core with a `rst` pulse. It sits between the sample source and the core, in place of a hand-driven stimulus.

## Interface
Parameters:
- `DEPTH`, 32: sample FIFO entries; power of two.
- `CW`, `$clog2(DEPTH+1)`: batch-count width.
- `DRAIN_TIMEOUT`, 63: maximum DRAIN cycles before the batch is aborted.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: upstream sample valid.
- `in_data` in 8: signed sample.
- `in_ready` out 1: FIFO not full; a write occurs when `in_valid & in_ready`.
- `go` in 1: batch command strobe.
- `n_cfg` in 3: N for the batch.
- `count` in CW: samples per batch, 1..DEPTH.
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle pulse at batch end.
- `cfg_err` out 1: one-cycle pulse when `go` is rejected.
- `timeout` out 1: sticky flag; cleared by the next accepted `go`.
- `core_start` out 1: to core `start`.
- `core_N` out 3: to core `N`.
- `core_X` out 8: to core `X`.
- `core_rst` out 1: to core `rst`.
- `core_ready` in 1: core accepts X this cycle.
- `core_valid` in 1: core result strobe.
- `core_overflow` in 1: core overflow flag.
- `core_error` in 1: core error flag.
- `ovf_cnt` out 16: overflow count (see Configuration).
- `err_cnt` out 16: error count (see Configuration).

## Operation
FSM states: IDLE, START, SETN, FEED, DRAIN, CLR, GAP.
- IDLE:
  - `go` with `count` in 1..DEPTH is accepted: latch `n_cfg` and `count`, clear `issued`, `received` and `timeout`, go to START.
  - Any other `go` is rejected: pulse `cfg_err`, stay in IDLE.
  - `go` while `busy` is ignored silently.
- START: `core_start`=1 for exactly one cycle → SETN.
- SETN: one wait cycle; `core_N` is held from START through GAP → FEED.
- FEED:
  - `core_X` = FIFO head.
  - Pop at an edge with `core_ready` & FIFO not empty; `issued`++.
  - If the FIFO is empty, hold `core_X` at its last value and do not advance `issued`.
  - Go to DRAIN on the edge where `issued` reaches `count`.
- DRAIN:
  - Stay at least DMIN cycles: DMIN = 3 if `core_N` ≤ 4, else 7.
  - Leave once `received` == `count` and DMIN has elapsed.
  - If the drain counter reaches DRAIN_TIMEOUT first, set `timeout` and leave anyway.
  - Next state is CLR in both cases.
- CLR: `core_rst`=1 for one cycle → GAP.
- GAP: one idle cycle, `done`=1 → IDLE.
- `received` increments on every `core_valid` cycle from START through DRAIN.
- `busy`=1 in every state except IDLE.
- FIFO writes are accepted in any state; upstream may load the next batch during the current one.
- A simultaneous push and pop on a full FIFO is allowed; the entry count is unchanged.
- Counters saturate at all-ones and never wrap.
- Reset (including mid-batch):
  - State goes to IDLE and the FIFO is emptied.
  - All outputs 0, except `in_ready`=1.
  - `core_rst`=0 during reset; the system `rst` reaches the core separately.

## Timing
- All outputs are registered.
- Cycle-level sequence, with `go` sampled at edge E0:
  - `core_start` high in the cycle after E0.
  - SETN in the next cycle.
  - The first `core_X` is valid starting 3 cycles after E0.
- Minimum batch length: 3 + `count` + DMIN + 2 cycles, given a full FIFO and `core_ready` held high.
- `in_ready` deasserts in the cycle after the write that fills the FIFO.
- `done` and the IDLE state coincide with the cycle after GAP ends; a new `go` can be accepted in that cycle.

## Configuration
- `FEEDER_STATS_EN` defined:
  - `ovf_cnt` increments on `core_valid & core_overflow`.
  - `err_cnt` increments on `core_error`.
  - Both are 16-bit, saturating, cleared only by `rst`.
- Undefined: `ovf_cnt` and `err_cnt` are tied to 0 and the counters are not synthesized.

## Structure
- Package `maclaurin_pkg` holds:
  - the state enum;
  - `XW`=8 and `NW`=3;
  - `DMIN_LO`=3 and `DMIN_HI`=7;
  - the N threshold 4.
- One sub-module, `sample_fifo`: synchronous FIFO, parameter DEPTH, with push/pop/full/empty and a registered head.

## Test plan
1. Load 20 samples, `go` with N=2, count=20, `core_ready` always 1, core returning 20 valids:
   - `core_start` pulses once;
   - 20 X values appear in order;
   - DRAIN ≥ 3 cycles;
   - one `core_rst` pulse, then `done`.
2. N=7, count=5, `core_ready` toggling 1/0: exactly 5 pops, only on ready-high edges; DRAIN ≥ 7 cycles.
3. `go` with count=0, then `go` with count=DEPTH+1: `cfg_err` pulses twice and `core_start` never asserts.
4. count=4 with only 2 samples loaded, then 2 more written after 10 cycles: FEED holds `core_X` stable, then completes 4 issues.
5. count=3 and the core returns 1 valid: `timeout`=1 after 63 DRAIN cycles, then CLR; the next `go` clears `timeout`.
6. `rst` mid-FEED, then with `FEEDER_STATS_EN` defined, 3 overflow valids:
   - after the reset, `busy`=0 and `in_ready`=1;
   - `ovf_cnt`=3.
